// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, event indices and reset image for the physical register state table
package regfile_pkg;
  typedef enum logic [1:0] {
    PREG_FREE    = 2'b00,
    PREG_PENDING = 2'b01,
    PREG_READY   = 2'b10,
    PREG_STALE   = 2'b11
  } preg_state_e;
  localparam int PREG_ZERO = 0;
  localparam int EV_ALLOC = 0;
  localparam int EV_WB = 1;
  localparam int EV_SUP = 2;
  localparam int EV_RCL = 3;
  localparam int EV_COUNT = 4;
  function automatic preg_state_e preg_reset_state(input int idx, input int arch);
    return (idx < arch) ? PREG_READY : PREG_FREE;
  endfunction
endpackage

// File: rtl/preg_state_cell.sv
// preg_state_cell: next-state and illegal-event logic for one physical register entry
module preg_state_cell
  import regfile_pkg::*;
#(
  parameter bit HARDWIRED = 1'b0
) (
  input  logic [1:0]          state_i,
  input  logic [EV_COUNT-1:0] hit_i,
  input  logic                dup_i,
  input  logic                flush_i,
  output logic [1:0]          state_o,
  output logic                illegal_o
);
  logic multi;
  logic match;
  logic [1:0] ev_src;
  // Each event's source state encodes one below its destination, so dst = src + 1.
  always_comb begin
    multi = dup_i | ((hit_i & (hit_i - 4'd1)) != 4'd0);
    ev_src = hit_i[EV_ALLOC] ? PREG_FREE : hit_i[EV_WB] ? PREG_PENDING : hit_i[EV_SUP] ? PREG_READY : PREG_STALE;
    match = (|hit_i) & ~multi & (state_i == ev_src);
    state_o = HARDWIRED ? PREG_READY : flush_i ? PREG_FREE : match ? ev_src + 2'd1 : state_i;
    illegal_o = ~HARDWIRED & ~flush_i & (|hit_i) & ~match;
  end
endmodule

// File: rtl/phys_reg_state_table.sv
// phys_reg_state_table: lifecycle state (FREE/PENDING/READY/STALE) of every physical register with multi-port events
module phys_reg_state_table
  import regfile_pkg::*;
#(
  parameter int PHYS_COUNT = 128,
  parameter int ARCH_COUNT = 32,
  parameter int ALLOC_PORTS = 4,
  parameter int WB_PORTS = 4,
  parameter int COMMIT_PORTS = 4,
  parameter int READ_PORTS = 8,
  parameter int ADDR_WIDTH = $clog2(PHYS_COUNT)
) (
  input  logic                                    clk,
  input  logic                                    sync_rst_n,
  input  logic [ALLOC_PORTS-1:0]                  alloc_en,
  input  logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]  alloc_addr,
  input  logic [WB_PORTS-1:0]                     wb_en,
  input  logic [WB_PORTS-1:0][ADDR_WIDTH-1:0]     wb_addr,
  input  logic [COMMIT_PORTS-1:0]                 sup_en,
  input  logic [COMMIT_PORTS-1:0][ADDR_WIDTH-1:0] sup_addr,
  input  logic [COMMIT_PORTS-1:0]                 rcl_en,
  input  logic [COMMIT_PORTS-1:0][ADDR_WIDTH-1:0] rcl_addr,
  input  logic                                    flush,
  input  logic [PHYS_COUNT-1:0]                   flush_mask,
  input  logic [READ_PORTS-1:0]                   rd_en,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [READ_PORTS-1:0][1:0]              rd_state,
  output logic [PHYS_COUNT-1:0]                   free_vec,
  output logic [ADDR_WIDTH:0]                     free_count,
  output logic                                    illegal
);
  logic [PHYS_COUNT-1:0][1:0] state_q, state_d;
  logic [PHYS_COUNT-1:0][EV_COUNT-1:0] hit;
  logic [PHYS_COUNT-1:0] dup, cell_ill, free_d, free_vec_q;
  logic [READ_PORTS-1:0][1:0] rd_state_q, rd_state_d;
  logic [ADDR_WIDTH:0] free_count_q, free_count_d;
  logic illegal_q, illegal_d;
  // dup flags a second port of the same event type landing on an already-hit entry.
  always_comb begin
    hit = '0;
    dup = '0;
    for (int r = 0; r < PHYS_COUNT; r++) begin
      for (int p = 0; p < ALLOC_PORTS; p++)
        if (alloc_en[p] && alloc_addr[p] == ADDR_WIDTH'(r)) begin
          dup[r] = dup[r] | hit[r][EV_ALLOC];
          hit[r][EV_ALLOC] = 1'b1;
        end
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_en[p] && wb_addr[p] == ADDR_WIDTH'(r)) begin
          dup[r] = dup[r] | hit[r][EV_WB];
          hit[r][EV_WB] = 1'b1;
        end
      for (int p = 0; p < COMMIT_PORTS; p++)
        if (sup_en[p] && sup_addr[p] == ADDR_WIDTH'(r)) begin
          dup[r] = dup[r] | hit[r][EV_SUP];
          hit[r][EV_SUP] = 1'b1;
        end
      for (int p = 0; p < COMMIT_PORTS; p++)
        if (rcl_en[p] && rcl_addr[p] == ADDR_WIDTH'(r)) begin
          dup[r] = dup[r] | hit[r][EV_RCL];
          hit[r][EV_RCL] = 1'b1;
        end
    end
  end
  for (genvar g = 0; g < PHYS_COUNT; g++) begin : g_cell
    preg_state_cell #(.HARDWIRED(g == PREG_ZERO)) u_cell (
      .state_i  (state_q[g]),
      .hit_i    (hit[g]),
      .dup_i    (dup[g]),
      .flush_i  (flush & flush_mask[g]),
      .state_o  (state_d[g]),
      .illegal_o(cell_ill[g])
    );
  end
  always_comb begin
    free_count_d = '0;
    for (int r = 0; r < PHYS_COUNT; r++) begin
      free_d[r] = state_d[r] == PREG_FREE;
      free_count_d = free_count_d + (ADDR_WIDTH+1)'(free_d[r]);
    end
    for (int p = 0; p < READ_PORTS; p++)
      rd_state_d[p] = rd_en[p] ? state_d[rd_addr[p]] : rd_state_q[p];
    illegal_d = illegal_q | (|cell_ill);
  end
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      for (int r = 0; r < PHYS_COUNT; r++) begin
        state_q[r] <= preg_reset_state(r, ARCH_COUNT);
        free_vec_q[r] <= preg_reset_state(r, ARCH_COUNT) == PREG_FREE;
      end
      rd_state_q <= '0;
      free_count_q <= (ADDR_WIDTH+1)'(PHYS_COUNT - ARCH_COUNT);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_state_q <= rd_state_d;
      free_vec_q <= free_d;
      free_count_q <= free_count_d;
      illegal_q <= illegal_d;
    end
  end
  assign rd_state = rd_state_q;
  assign free_vec = free_vec_q;
  assign free_count = free_count_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_phys_reg_state_table.sv
// tb_phys_reg_state_table: scoreboard bench with a register-lifecycle reference model and directed plus random stimulus
module tb_phys_reg_state_table;
  localparam int P = 128, A = 32, AP = 4, WP = 4, CP = 4, RP = 8, AW = 7;
  localparam int FREE = 0, PEND = 1, READY = 2, STALE = 3;
  localparam int SRC [4] = '{FREE, PEND, READY, STALE};
  localparam int DST [4] = '{PEND, READY, STALE, FREE};
  logic clk, sync_rst_n, flush, illegal;
  logic [AP-1:0] alloc_en;
  logic [AP-1:0][AW-1:0] alloc_addr;
  logic [WP-1:0] wb_en;
  logic [WP-1:0][AW-1:0] wb_addr;
  logic [CP-1:0] sup_en, rcl_en;
  logic [CP-1:0][AW-1:0] sup_addr, rcl_addr;
  logic [P-1:0] flush_mask, free_vec;
  logic [RP-1:0] rd_en;
  logic [RP-1:0][AW-1:0] rd_addr;
  logic [RP-1:0][1:0] rd_state;
  logic [AW:0] free_count;
  typedef struct {
    logic [RP-1:0][1:0] rd;
    logic [P-1:0] fv;
    int fc;
    bit ill;
  } exp_t;
  exp_t q[$];
  int m_st[P];
  int m_rd[RP];
  bit m_ill;
  bit used[P];
  int errors = 0, checks = 0;
  phys_reg_state_table dut (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .sup_en(sup_en), .sup_addr(sup_addr),
    .rcl_en(rcl_en), .rcl_addr(rcl_addr),
    .flush(flush), .flush_mask(flush_mask),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_state(rd_state), .free_vec(free_vec),
    .free_count(free_count), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic clear();
    sync_rst_n = 1'b1;
    alloc_en = '0; alloc_addr = '0;
    wb_en = '0; wb_addr = '0;
    sup_en = '0; sup_addr = '0;
    rcl_en = '0; rcl_addr = '0;
    flush = 1'b0; flush_mask = '0;
    rd_en = '0; rd_addr = '0;
  endtask
  // Reference model: apply one cycle of events to the table, queue the expected outputs, then advance a clock.
  task automatic step();
    int nev[P];
    int typ[P];
    exp_t e;
    nev = '{default: 0};
    typ = '{default: 0};
    if (!sync_rst_n) begin
      for (int r = 0; r < P; r++) m_st[r] = (r < A) ? READY : FREE;
      for (int p = 0; p < RP; p++) m_rd[p] = FREE;
      m_ill = 1'b0;
    end else begin
      for (int p = 0; p < AP; p++) if (alloc_en[p]) begin nev[alloc_addr[p]]++; typ[alloc_addr[p]] = 0; end
      for (int p = 0; p < WP; p++) if (wb_en[p]) begin nev[wb_addr[p]]++; typ[wb_addr[p]] = 1; end
      for (int p = 0; p < CP; p++) if (sup_en[p]) begin nev[sup_addr[p]]++; typ[sup_addr[p]] = 2; end
      for (int p = 0; p < CP; p++) if (rcl_en[p]) begin nev[rcl_addr[p]]++; typ[rcl_addr[p]] = 3; end
      for (int r = 1; r < P; r++) begin
        if (flush && flush_mask[r]) m_st[r] = FREE;
        else if (nev[r] > 1) m_ill = 1'b1;
        else if (nev[r] == 1) begin
          if (m_st[r] == SRC[typ[r]]) m_st[r] = DST[typ[r]];
          else m_ill = 1'b1;
        end
      end
      for (int p = 0; p < RP; p++) if (rd_en[p]) m_rd[p] = m_st[rd_addr[p]];
    end
    e.fc = 0;
    for (int r = 0; r < P; r++) begin
      e.fv[r] = (m_st[r] == FREE);
      e.fc += (m_st[r] == FREE) ? 1 : 0;
    end
    for (int p = 0; p < RP; p++) e.rd[p] = 2'(m_rd[p]);
    e.ill = m_ill;
    q.push_back(e);
    @(posedge clk);
    #2;
    clear();
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < RP; p++) chk($sformatf("rd_state[%0d]", p), int'(rd_state[p]), int'(e.rd[p]));
        checks++;
        if (free_vec !== e.fv) begin
          errors++;
          $display("FAIL free_vec: got %h expected %h", free_vec, e.fv);
        end
        chk("free_count", int'(free_count), e.fc);
        chk("illegal", int'(illegal), int'(e.ill));
      end
    end
  end
  task automatic pick(input int want, input bit legal, output int a);
    int s;
    s = $urandom_range(P-1, 0);
    a = -1;
    if (!legal && $urandom_range(3, 0) == 0) begin
      a = $urandom_range(P-1, 0);
      return;
    end
    for (int i = 0; i < P; i++) begin
      int k;
      k = (s + i) % P;
      if (k != 0 && m_st[k] == want && !used[k]) begin
        a = k;
        used[k] = 1'b1;
        return;
      end
    end
  endtask
  task automatic rand_cycle(input bit legal);
    int a;
    used = '{default: 1'b0};
    for (int p = 0; p < AP; p++) if ($urandom_range(1, 0) == 1) begin
      pick(FREE, legal, a);
      if (a >= 0) begin alloc_en[p] = 1'b1; alloc_addr[p] = AW'(a); end
    end
    for (int p = 0; p < WP; p++) if ($urandom_range(1, 0) == 1) begin
      pick(PEND, legal, a);
      if (a >= 0) begin wb_en[p] = 1'b1; wb_addr[p] = AW'(a); end
    end
    for (int p = 0; p < CP; p++) if ($urandom_range(1, 0) == 1) begin
      pick(READY, legal, a);
      if (a >= 0) begin sup_en[p] = 1'b1; sup_addr[p] = AW'(a); end
    end
    for (int p = 0; p < CP; p++) if ($urandom_range(1, 0) == 1) begin
      pick(STALE, legal, a);
      if (a >= 0) begin rcl_en[p] = 1'b1; rcl_addr[p] = AW'(a); end
    end
    if ($urandom_range(9, 0) == 0) begin
      flush = 1'b1;
      flush_mask = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int p = 0; p < RP; p++) begin
      rd_en[p] = 1'($urandom_range(1, 0));
      rd_addr[p] = AW'($urandom_range(P-1, 0));
    end
    if (!legal && $urandom_range(29, 0) == 0) sync_rst_n = 1'b0;
    step();
  endtask
  initial begin : stim
    logic [P-1:0] rimg;
    rimg = {{(P-A){1'b1}}, {A{1'b0}}};
    clear();
    sync_rst_n = 1'b0;
    step();
    rd_en[3:0] = 4'hf;
    rd_addr[0] = 7'd0; rd_addr[1] = 7'd31; rd_addr[2] = 7'd32; rd_addr[3] = 7'd127;
    step();
    chk("reset rd0", int'(rd_state[0]), READY);
    chk("reset rd31", int'(rd_state[1]), READY);
    chk("reset rd32", int'(rd_state[2]), FREE);
    chk("reset rd127", int'(rd_state[3]), FREE);
    chk("reset free_count", int'(free_count), 96);
    chk("reset illegal", int'(illegal), 0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin alloc_en[0] = 1'b1; alloc_addr[0] = 7'd40; end
        1: begin wb_en[0] = 1'b1; wb_addr[0] = 7'd40; end
        2: begin sup_en[0] = 1'b1; sup_addr[0] = 7'd40; end
        default: begin rcl_en[0] = 1'b1; rcl_addr[0] = 7'd40; end
      endcase
      rd_en[0] = 1'b1; rd_addr[0] = 7'd40;
      step();
      chk($sformatf("life40 step%0d", k), int'(rd_state[0]), DST[k]);
      if (k == 0) chk("life40 free_count alloc", int'(free_count), 95);
      if (k == 3) chk("life40 free_count rcl", int'(free_count), 96);
      step();
    end
    alloc_en[1:0] = 2'b11; alloc_addr[0] = 7'd50; alloc_addr[1] = 7'd51;
    step();
    alloc_en = 4'hf;
    for (int p = 0; p < 4; p++) alloc_addr[p] = AW'(33 + p);
    wb_en[1:0] = 2'b11; wb_addr[0] = 7'd50; wb_addr[1] = 7'd51;
    rd_en[5:0] = 6'h3f;
    for (int p = 0; p < 4; p++) rd_addr[p] = AW'(33 + p);
    rd_addr[4] = 7'd50; rd_addr[5] = 7'd51;
    step();
    for (int p = 0; p < 4; p++) chk($sformatf("multi alloc %0d", 33 + p), int'(rd_state[p]), PEND);
    chk("multi wb 50", int'(rd_state[4]), READY);
    chk("multi wb 51", int'(rd_state[5]), READY);
    chk("multi free_count", int'(free_count), 90);
    chk("multi illegal", int'(illegal), 0);
    alloc_en[2:0] = 3'b111; alloc_addr[0] = 7'd70; alloc_addr[1] = 7'd71; alloc_addr[2] = 7'd72;
    step();
    wb_en[1:0] = 2'b11; wb_addr[0] = 7'd71; wb_addr[1] = 7'd72;
    step();
    sup_en[0] = 1'b1; sup_addr[0] = 7'd72;
    step();
    chk("pre-flush free_count", int'(free_count), 87);
    flush = 1'b1;
    flush_mask[70] = 1'b1; flush_mask[71] = 1'b1; flush_mask[0] = 1'b1;
    wb_en[0] = 1'b1; wb_addr[0] = 7'd70;
    rd_en[3:0] = 4'hf;
    rd_addr[0] = 7'd70; rd_addr[1] = 7'd71; rd_addr[2] = 7'd72; rd_addr[3] = 7'd0;
    step();
    chk("flush 70", int'(rd_state[0]), FREE);
    chk("flush 71", int'(rd_state[1]), FREE);
    chk("flush 72 unmasked", int'(rd_state[2]), STALE);
    chk("flush reg0", int'(rd_state[3]), READY);
    chk("flush free_count", int'(free_count), 89);
    chk("flush illegal", int'(illegal), 0);
    alloc_en[0] = 1'b1; alloc_addr[0] = 7'd0;
    rcl_en[0] = 1'b1; rcl_addr[0] = 7'd0;
    rd_en[0] = 1'b1; rd_addr[0] = 7'd0;
    step();
    chk("reg0 events", int'(rd_state[0]), READY);
    chk("reg0 illegal", int'(illegal), 0);
    wb_en[0] = 1'b1; wb_addr[0] = 7'd60;
    alloc_en[1:0] = 2'b11; alloc_addr[0] = 7'd61; alloc_addr[1] = 7'd61;
    rd_en[1:0] = 2'b11; rd_addr[0] = 7'd60; rd_addr[1] = 7'd61;
    step();
    chk("bad wb 60", int'(rd_state[0]), FREE);
    chk("dup alloc 61", int'(rd_state[1]), FREE);
    chk("illegal set", int'(illegal), 1);
    step();
    chk("illegal sticky", int'(illegal), 1);
    repeat (3) rand_cycle(1'b0);
    alloc_en = 4'hf; wb_en = 4'hf; sup_en = 4'hf; rcl_en = 4'hf;
    for (int p = 0; p < 4; p++) begin
      alloc_addr[p] = AW'(90 + p); wb_addr[p] = AW'(33 + p);
      sup_addr[p] = AW'(1 + p); rcl_addr[p] = AW'(72);
    end
    flush = 1'b1; flush_mask = '1;
    rd_en = '1;
    sync_rst_n = 1'b0;
    step();
    chk("burst reset free_count", int'(free_count), 96);
    chk("burst reset illegal", int'(illegal), 0);
    chk("burst reset rd_state", int'(rd_state[0]), FREE);
    checks++;
    if (free_vec !== rimg) begin
      errors++;
      $display("FAIL burst reset free_vec: got %h expected %h", free_vec, rimg);
    end
    for (int s = 0; s < 20; s++) begin
      sync_rst_n = 1'b0;
      step();
      repeat (40) rand_cycle(s % 2 == 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phys_reg_state_table.md
Name: phys_reg_state_table

Overview:
- Tracks the lifecycle state of every physical register in the renamed register file: FREE, PENDING, READY, STALE.
- Accepts per-cycle allocate, writeback, supersede and reclaim events from rename, execute and commit on parametrised port counts.
- Answers parametrised read ports for operand readiness and exports the free vector and free count to the free-list allocator.
- Sits between rename/dispatch and the physical register file; generalises the earlier fixed 4-bit state table with multi-port events, flush and error checking.

Parameters:
PHYS_COUNT, 128, number of physical registers (power of two, at least 2*ARCH_COUNT)
ARCH_COUNT, 32, architectural registers; physical 0..ARCH_COUNT-1 are mapped at reset
ALLOC_PORTS, 4, allocate ports from rename
WB_PORTS, 4, writeback ports from execute
COMMIT_PORTS, 4, supersede and reclaim ports from commit (each)
READ_PORTS, 8, state query ports
ADDR_WIDTH, $clog2(PHYS_COUNT), physical register index width

Ports:
clk  in  1  clock
sync_rst_n  in  1  synchronous active-low reset
alloc_en  in  ALLOC_PORTS  allocate strobe per port
alloc_addr  in  ADDR_WIDTH x ALLOC_PORTS  register to move FREE->PENDING
wb_en  in  WB_PORTS  writeback strobe
wb_addr  in  ADDR_WIDTH x WB_PORTS  register to move PENDING->READY
sup_en  in  COMMIT_PORTS  supersede strobe (old mapping of a committed dest)
sup_addr  in  ADDR_WIDTH x COMMIT_PORTS  register to move READY->STALE
rcl_en  in  COMMIT_PORTS  reclaim strobe
rcl_addr  in  ADDR_WIDTH x COMMIT_PORTS  register to move STALE->FREE
flush  in  1  squash speculative allocations
flush_mask  in  PHYS_COUNT  registers forced to FREE on flush
rd_en  in  READ_PORTS  query strobe
rd_addr  in  ADDR_WIDTH x READ_PORTS  query index
rd_state  out  2 x READ_PORTS  registered state per query port
free_vec  out  PHYS_COUNT  1 = register FREE (registered)
free_count  out  ADDR_WIDTH+1  population of free_vec (registered)
illegal  out  1  sticky illegal-transition flag

Behaviour:
- Reset is synchronous and active-low (sync_rst_n, single clock clk). On reset: regs 0..ARCH_COUNT-1 = READY, others FREE; rd_state = all 0 (FREE); free_vec matches; free_count = PHYS_COUNT-ARCH_COUNT; illegal = 0. Reset overrides every event in the same cycle.
- Encoding (package enum): FREE=2'b00, PENDING=2'b01, READY=2'b10, STALE=2'b11.
- Legal transitions, applied at the clock edge: alloc FREE->PENDING; wb PENDING->READY; sup READY->STALE; rcl STALE->FREE.
- Register 0 is hardwired READY. Events addressed to it are ignored and are not illegal.
- Per register per cycle, at most one event may target it; two strobed ports on the same index are also a conflict.
- Any event whose source state does not match, or any conflict: that register keeps its state and illegal sets; illegal clears only on reset. Other registers still update.
- flush=1: every register with flush_mask=1 becomes FREE regardless of state or concurrent events (bit 0 ignored). Events to unmasked registers are applied normally. A flush-overridden event is not illegal.
- Reads: rd_state[p] is registered at the same edge as the updates, so it shows the post-update state one cycle after rd_en. With rd_en=0, rd_state[p] holds its value. A writeback in cycle N to the queried register makes rd_state = READY in cycle N+1.
- free_vec and free_count reflect the post-update table one cycle after the edge, i.e. consistent with the table every cycle. free_count is the full popcount, with no wrap-around; the range is 0..PHYS_COUNT-1.
- Latency: single cycle for every event; no back-pressure; no handshakes beyond the strobes.

Decomposition:
- Shared package regfile_pkg: typedef enum logic [1:0] preg_state_e; PREG_ZERO index constant; reset-state function of index and ARCH_COUNT.
- One sub-module, preg_state_cell. Per entry it takes one-hot event hits plus the flush bit. It produces the next state and an illegal bit. It is instantiated PHYS_COUNT times by a generate loop.
- Address decode, read muxes, popcount and the illegal OR-reduce stay in the top module.

Test Plan:
- Reset, then read regs 0, 31, 32, 127 -> rd_state READY, READY, FREE, FREE; free_count=96; illegal=0.
- Alloc 40 in cycle 1, wb 40 in cycle 3, sup 40 in cycle 5, rcl 40 in cycle 7 -> states PENDING, READY, STALE, FREE on the edges; free_count 95 after cycle 1 and 96 after cycle 7.
- Four allocs (33,34,35,36) plus two wbs on previously PENDING 50,51, all in the same cycle -> all six update; free_count drops by 4; illegal=0.
- wb to FREE reg 60, and alloc 61 on two ports in the same cycle -> 60 stays FREE, 61 stays FREE, illegal=1 and stays 1 until reset.
- Regs 70 (PENDING), 71 (READY), 72 (STALE) with flush and mask bits 70, 71 set, while wb 70 is strobed -> 70 and 71 FREE, 72 STALE, illegal=0; free_count +2.
- Event to reg 0 (alloc, rcl) -> stays READY, illegal=0. Assert sync_rst_n=0 in the middle of a burst of events -> next cycle matches the reset image exactly.
